spm_seq_ctrl: RTL
=================

// Module: spm_seq_ctrl
// PURPOSE
//   Sequencer for the serial-parallel multiplier (spm) built from the genblk1[*].csa cells.
//   Accepts one multiplicand/multiplier pair per valid/ready handshake.
//   Drives the spm parallel x operand, clears the array and streams y LSB-first.
//   Deserialises the serial product into a 2*SIZE-bit result.
//   Sits between the bus-side operand registers and the spm instance.
// PARAMETERS
//   SIZE    32  operand width; must equal the spm instance width
//   P_LAT   1   cycles from driving y bit k on spm_y to product bit k on spm_p
//   SIGNED  1   1: two's-complement; y sign bit repeated during upper half. 0: zeros in upper half
// PORTS
//   clk        in   1        single clock, rising edge
//   rst        in   1        asynchronous, active-low reset
//   in_valid   in   1        operand pair valid
//   in_ready   out  1        ctrl idle and able to accept
//   mc         in   SIZE     multiplicand (parallel x)
//   mp         in   SIZE     multiplier (serialised onto y)
//   abort      in   1        synchronous cancel of the current operation
//   out_valid  out  1        prod valid
//   out_ready  in   1        consumer accepts prod
//   prod       out  2*SIZE   product
//   spm_x      out  SIZE     to spm x input, held for the whole operation
//   spm_y      out  1        to spm serial y input
//   spm_clr    out  1        active-high synchronous clear of spm csa state
//   spm_p      in   1        serial product bit from spm
// BEHAVIOUR
//   Reset (rst=0), async:
//     - state=IDLE; cnt=0; x_q, y_q, prod = 0
//     - in_ready=1; out_valid=0; spm_y=0; spm_clr=1
//   FSM IDLE -> CLEAR -> RUN -> DONE -> IDLE.
//   IDLE:
//     - in_ready=1; spm_clr=1
//     - on in_valid: latch mc->x_q and mp->y_q; go to CLEAR
//   CLEAR (1 cycle):
//     - spm_clr=1; spm_x=x_q; cnt<=0; go to RUN
//   RUN (2*SIZE+P_LAT cycles, cnt 0..2*SIZE+P_LAT-1):
//     - spm_clr=0
//     - spm_y = y_q[cnt] while cnt<SIZE
//     - spm_y = (SIGNED ? y_q[SIZE-1] : 0) while SIZE<=cnt<2*SIZE
//     - spm_y = 0 afterwards
//     - if cnt>=P_LAT: prod <= {spm_p, prod[2*SIZE-1:1]}, so the final prod is LSB-aligned
//     - after the last cycle go to DONE
//   DONE:
//     - out_valid=1; prod held stable; spm_clr=1
//     - on out_ready: go to IDLE
//     - in_ready=0 in DONE: no accept in the same cycle as the output handshake
//   Latency: accept at cycle t; out_valid first high at t+2+2*SIZE+P_LAT.
//   out_valid held until out_ready, with unbounded back-pressure; prod does not change while out_valid=1.
//   abort:
//     - in CLEAR or RUN: next state IDLE, spm_clr=1, prod unchanged, no out_valid
//     - in IDLE or DONE: ignored
//     - if abort=1 and in_valid=1 in IDLE, the accept takes effect
//   cnt width = $clog2(2*SIZE+P_LAT+1); cnt never wraps (FSM exits first).
//   rst deassertion mid-operation: restart in IDLE with the reset values above; no partial result is presented.
//   spm_x driven from x_q in every state; x_q changes only on accept.
// STRUCTURE
//   Package spm_pkg holds:
//     - typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} spm_state_e
//     - localparam function for RUN length (2*SIZE+P_LAT)
//   One sub-module: spm_ser_shift, a SIZE-bit load/shift register feeding spm_y with sign-repeat.
//   FSM, counter and product deserialiser stay in the top module.
// TESTING  (SIZE=8, P_LAT=1, SIGNED=1 unless stated; paired with the real spm instance)
//   1. mc=5, mp=3 -> prod=16'h000F; out_valid rises exactly 19 cycles after the accept.
//   2. mc=-3 (8'hFD), mp=7 -> prod=16'hFFEB; mc=8'h80, mp=8'h80 -> 16'h4000.
//   3. SIGNED=0: mc=8'hFF, mp=8'hFF -> prod=16'hFE01.
//   4. Back-pressure: out_ready low 10 cycles -> out_valid and prod stable, in_ready=0; then a back-to-back op.
//   5. abort at RUN cnt=4 -> IDLE next cycle, spm_clr=1, no out_valid; next op 6*7 -> 16'h002A.
//   6. rst pulsed low mid-RUN -> all outputs at reset values asynchronously; subsequent op gives the correct result.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared types and sizing helpers for the spm sequencer.
// The FSM state encoding lives here so the sequencer and any future
// debug logic agree on the state values.
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } spm_state_e;

    // Number of cycles spent in RUN: 2*SIZE product bits plus the spm pipeline latency.
    function automatic int spm_run_len(input int size, input int p_lat);
        return 2 * size + p_lat;
    endfunction

    // Width of the RUN counter; one spare code so the counter never wraps.
    function automatic int spm_cnt_width(input int size, input int p_lat);
        return $clog2(2 * size + p_lat + 1);
    endfunction

endpackage

// File: rtl/spm_seq_ctrl_if.sv
// Bus-side handshake bundle of the spm sequencer: operand pair in,
// product out, plus the synchronous abort.
interface spm_seq_ctrl_if #(
    parameter int SIZE = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [SIZE-1:0]   mc;
    logic [SIZE-1:0]   mp;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [2*SIZE-1:0] prod;

    // The operand producer / product consumer side.
    modport master (
        output in_valid, mc, mp, abort, out_ready,
        input  in_ready, out_valid, prod
    );

    // The sequencer side.
    modport slave (
        input  in_valid, mc, mp, abort, out_ready,
        output in_ready, out_valid, prod
    );
endinterface

// File: rtl/spm_ser_shift.sv
// Load/shift register that serialises the multiplier LSB-first onto the
// spm y input. Each shift moves the register right by one; the bit shifted
// in at the top is either the sign bit (so after SIZE shifts the output
// repeats the sign) or zero for unsigned operation.
module spm_ser_shift #(
    parameter int SIZE        = 32,
    parameter bit SIGN_REPEAT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic [SIZE-1:0] load_data,
    input  logic            shift_en,
    output logic            ser_bit
);

    logic [SIZE-1:0] y_q;
    logic [SIZE-1:0] y_d;
    logic            fill_bit;

    assign fill_bit = SIGN_REPEAT ? y_q[SIZE-1] : 1'b0;
    assign ser_bit  = y_q[0];

    // Next value: a load takes priority over a shift, otherwise hold.
    always_comb begin
        y_d = y_q;
        if (load_en) begin
            y_d = load_data;
        end else if (shift_en) begin
            y_d = {fill_bit, y_q[SIZE-1:1]};
        end
    end

    // Multiplier register, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer for the serial-parallel multiplier. Accepts one operand pair,
// holds the multiplicand on spm_x, clears the csa array for one cycle,
// streams the multiplier LSB-first (sign-repeated in the upper half when
// signed) and deserialises the returned product bits into prod.
module spm_seq_ctrl
    import spm_pkg::*;
#(
    parameter int SIZE   = 32,
    parameter int P_LAT  = 1,
    parameter int SIGNED = 1
) (
    input  logic               clk,
    input  logic               rst,
    spm_seq_ctrl_if.slave      bus,
    output logic [SIZE-1:0]    spm_x,
    output logic               spm_y,
    output logic               spm_clr,
    input  logic               spm_p
);

    localparam int RUN_LEN = spm_run_len(SIZE, P_LAT);
    localparam int CNT_W   = spm_cnt_width(SIZE, P_LAT);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_PLAT  = CNT_W'(P_LAT);
    localparam logic [CNT_W-1:0] CNT_YSTOP = CNT_W'(2 * SIZE);

    spm_state_e        state_q;
    spm_state_e        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [SIZE-1:0]   x_q;
    logic [SIZE-1:0]   x_d;
    logic [2*SIZE-1:0] prod_q;
    logic [2*SIZE-1:0] prod_d;

    logic              load_y;
    logic              shift_y;
    logic              y_bit;

    // Multiplier serialiser; loaded on accept, shifted once per RUN cycle.
    spm_ser_shift #(
        .SIZE        (SIZE),
        .SIGN_REPEAT (SIGNED != 0)
    ) u_ser_shift (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_y),
        .load_data (bus.mp),
        .shift_en  (shift_y),
        .ser_bit   (y_bit)
    );

    // Next-state, counter, operand latch and product deserialiser.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        prod_d  = prod_q;
        load_y  = 1'b0;
        shift_y = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.mc;
                    load_y  = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = bus.abort ? IDLE : RUN;
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    shift_y = 1'b1;
                    if (cnt_q >= CNT_PLAT) begin
                        prod_d = {spm_p, prod_q[2*SIZE-1:1]};
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, multiplicand and product registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            prod_q  <= prod_d;
        end
    end

    // The csa array is held clear whenever it is not multiplying, and
    // also in the cycle an abort is seen so no stale partial sum survives.
    assign spm_clr       = (state_q != RUN) || bus.abort;
    assign spm_y         = (state_q == RUN) && (cnt_q < CNT_YSTOP) && y_bit;
    assign spm_x         = x_q;
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.prod      = prod_q;

endmodule
